// File: rtl/cnn_pkg.sv
// Shared types and the pooling combine operator for the CNN datapath.
// combine() works on a wide signed accumulator so callers pick the bits they need.
package cnn_pkg;

  localparam int PIX_W = 16;
  localparam int ACC_W = 40;

  typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} pool_state_e;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t combine(pool_mode_e mode, acc_t a, acc_t b);
    acc_t r;
    if (mode == POOL_MAX) r = (a > b) ? a : b;
    else                  r = a + b;
    return r;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Half-row store for the pooling engine: one write port, combinational read.
module pool_row_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool_stream_engine.sv
// Streaming 2x2 / stride-2 average or max pooling over M square maps of edge N.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | consuming pixels, emitting pooled results
//   FIN   | one-cycle done pulse, then back to IDLE
module pool_stream_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int MAX_MAP  = 32,
  parameter int MAX_MAPS = 128,
  parameter int SZ_W     = $clog2(MAX_MAP + 1),
  parameter int NM_W     = $clog2(MAX_MAPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [SZ_W-1:0]   cfg_map_size,
  input  logic [NM_W-1:0]   cfg_num_maps,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int BUF_D  = MAX_MAP / 2;
  localparam int BUF_AW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int BUF_W  = DATA_W + 1;

  pool_state_e       state_q, state_d;
  pool_mode_e        mode_q, mode_d;
  logic [SZ_W-1:0]   size_q, size_d;
  logic [NM_W-1:0]   nmaps_q, nmaps_d;
  logic [SZ_W-1:0]   col_q, col_d;
  logic [SZ_W-1:0]   row_q, row_d;
  logic [NM_W-1:0]   map_q, map_d;
  logic [DATA_W-1:0] pair_q, pair_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              in_done_q, in_done_d;

  logic              in_fire, out_fire;
  logic              col_end, row_end, map_end, last_pix, win_done;
  logic [SZ_W-1:0]   even_last;
  logic              rb_wr_en;
  logic [BUF_AW-1:0] rb_addr;
  logic [BUF_W-1:0]  rb_wr_data, rb_rd_data;
  acc_t              pix_x, pair_x, rb_x, pair_comb, win_comb;
  logic [DATA_W-1:0] win_res;
  logic              unused_bits;

  assign in_ready = (state_q == RUN) & !(out_valid_q & !out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  assign col_end   = (col_q == size_q - SZ_W'(1));
  assign row_end   = (row_q == size_q - SZ_W'(1));
  assign map_end   = (map_q == nmaps_q - NM_W'(1));
  assign last_pix  = col_end & row_end & map_end;
  assign win_done  = row_q[0] & col_q[0];
  assign even_last = {size_q[SZ_W-1:1], 1'b0} - SZ_W'(1);

  assign pix_x  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign pair_x = {{(ACC_W-DATA_W){pair_q[DATA_W-1]}}, pair_q};
  assign rb_x   = {{(ACC_W-BUF_W){rb_rd_data[BUF_W-1]}}, rb_rd_data};

  assign pair_comb = combine(mode_q, pair_x, pix_x);
  assign win_comb  = combine(mode_q, rb_x, pair_comb);
  // Dropping the two LSBs of the 4-pixel sum is a floor divide by 4.
  assign win_res   = (mode_q == POOL_AVG) ? win_comb[DATA_W+1:2] : win_comb[DATA_W-1:0];

  assign rb_wr_en   = in_fire & !row_q[0] & col_q[0];
  assign rb_wr_data = pair_comb[BUF_W-1:0];
  assign rb_addr    = col_q[BUF_AW:1];

  assign unused_bits = ^{pair_comb[ACC_W-1:BUF_W], win_comb[ACC_W-1:DATA_W+2]};

  pool_row_buffer #(
    .DEPTH (BUF_D),
    .WIDTH (BUF_W),
    .AW    (BUF_AW)
  ) u_row_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rb_wr_en),
    .wr_addr (rb_addr),
    .wr_data (rb_wr_data),
    .rd_addr (rb_addr),
    .rd_data (rb_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    size_d      = size_q;
    nmaps_d     = nmaps_q;
    col_d       = col_q;
    row_d       = row_q;
    map_d       = map_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q & !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_done_d   = in_done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = pool_mode_e'(cfg_mode);
          size_d    = cfg_map_size;
          nmaps_d   = cfg_num_maps;
          col_d     = '0;
          row_d     = '0;
          map_d     = '0;
          in_done_d = 1'b0;
          state_d   = (cfg_map_size < SZ_W'(2) || cfg_num_maps == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          if (!col_q[0]) pair_d = in_data;
          if (win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = win_res;
            out_last_d  = (row_q == even_last) && (col_q == even_last);
          end
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d = '0;
              map_d = map_q + NM_W'(1);
            end else begin
              row_d = row_q + SZ_W'(1);
            end
          end else begin
            col_d = col_q + SZ_W'(1);
          end
          // Odd N: the final pixel closes no window, so finish right away.
          if (last_pix) begin
            if (win_done) in_done_d = 1'b1;
            else          state_d   = FIN;
          end
        end
        if (in_done_q && out_fire) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= POOL_AVG;
      size_q      <= '0;
      nmaps_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      map_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      in_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      size_q      <= size_d;
      nmaps_q     <= nmaps_d;
      col_q       <= col_d;
      row_q       <= row_d;
      map_q       <= map_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      in_done_q   <= in_done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_stream_engine.sv
// Randomized bench for pool_stream_engine against a plain-arithmetic pooling model.
module tb_pool_stream_engine;

  localparam int DATA_W   = 16;
  localparam int MAX_MAP  = 32;
  localparam int MAX_MAPS = 128;
  localparam int SZ_W     = $clog2(MAX_MAP + 1);
  localparam int NM_W     = $clog2(MAX_MAPS + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              cfg_mode = 1'b0;
  logic [SZ_W-1:0]   cfg_map_size = '0;
  logic [NM_W-1:0]   cfg_num_maps = '0;
  logic              busy, done;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  int n_checks = 0;
  int n_errors = 0;
  int pix_q[$];
  int exp_d[$];
  bit exp_l[$];

  pool_stream_engine #(
    .DATA_W   (DATA_W),
    .MAX_MAP  (MAX_MAP),
    .MAX_MAPS (MAX_MAPS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_mode     (cfg_mode),
    .cfg_map_size (cfg_map_size),
    .cfg_num_maps (cfg_num_maps),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic build_expected(input bit mode, input int n, input int m);
    int base, a, b, c, d, h;
    exp_d.delete();
    exp_l.delete();
    h = n / 2;
    for (int mp = 0; mp < m; mp++) begin
      base = mp * n * n;
      for (int i = 0; i < h; i++) begin
        for (int j = 0; j < h; j++) begin
          a = pix_q[base + (2*i)*n + 2*j];
          b = pix_q[base + (2*i)*n + 2*j + 1];
          c = pix_q[base + (2*i+1)*n + 2*j];
          d = pix_q[base + (2*i+1)*n + 2*j + 1];
          exp_d.push_back(mode ? max4(a, b, c, d) : floor_div4(a + b + c + d));
          exp_l.push_back(i == h-1 && j == h-1);
        end
      end
    end
  endtask

  task automatic fill_random(input int count);
    pix_q.delete();
    for (int i = 0; i < count; i++) pix_q.push_back(int'($urandom_range(65535)) - 32768);
  endtask

  task automatic run_case(input string tag, input bit mode, input int n, input int m,
                          input int in_pct, input int out_pct, input bit stall, input bit chk_lat);
    int idx = 0, n_out = 0, n_done = 0, cyc = 0, n_exp;
    int last_in_cyc = -1, done_cyc = -1, stall_left = 0, held = 0, ev;
    bit stalled = 0, finished = 0, el;
    build_expected(mode, n, m);
    n_exp = exp_d.size();
    @(negedge clk);
    start = 1'b1; cfg_mode = mode;
    cfg_map_size = SZ_W'(n); cfg_num_maps = NM_W'(m);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq({tag, "_busy_after_start"}, int'(busy), 1);
    while (!finished && cyc < 40000) begin
      if (cyc > 0) @(negedge clk);
      start        = (cyc == 3);
      cfg_mode     = 1'($urandom);
      cfg_map_size = SZ_W'($urandom_range(0, MAX_MAP));
      cfg_num_maps = NM_W'($urandom_range(0, 3));
      if (stall && !stalled && out_valid) begin
        stalled = 1; stall_left = 5; held = int'($signed(out_data));
      end
      in_valid  = (idx < pix_q.size()) && ($urandom_range(99) < in_pct);
      in_data   = in_valid ? DATA_W'(pix_q[idx]) : DATA_W'($urandom);
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < out_pct);
      #1;
      if (stall_left > 0) begin
        check_eq({tag, "_stall_in_ready"}, int'(in_ready), 0);
        check_eq({tag, "_stall_out_data"}, int'($signed(out_data)), held);
        check_eq({tag, "_stall_out_valid"}, int'(out_valid), 1);
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) check_eq({tag, "_extra_out"}, 1, 0);
        else begin
          ev = exp_d.pop_front();
          el = exp_l.pop_front();
          check_eq({tag, "_out_data"}, int'($signed(out_data)), ev);
          check_eq({tag, "_out_last"}, int'(out_last), int'(el));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx == n * n * m) last_in_cyc = cyc;
      end
      if (done) begin
        n_done++; done_cyc = cyc; finished = 1;
      end
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!finished) check_eq({tag, "_timeout"}, 0, 1);
    check_eq({tag, "_in_count"}, idx, n * n * m);
    check_eq({tag, "_out_count"}, n_out, n_exp);
    check_eq({tag, "_done_count"}, n_done, 1);
    if (chk_lat) check_eq({tag, "_done_latency"}, done_cyc - last_in_cyc, 1);
    @(negedge clk);
    #1;
    check_eq({tag, "_done_drop"}, int'(done), 0);
    check_eq({tag, "_busy_drop"}, int'(busy), 0);
    check_eq({tag, "_out_valid_idle"}, int'(out_valid), 0);
  endtask

  task automatic run_degenerate(input string tag, input int n, input int m);
    @(negedge clk);
    start = 1'b1; cfg_mode = 1'b0;
    cfg_map_size = SZ_W'(n); cfg_num_maps = NM_W'(m);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq({tag, "_done"}, int'(done), 1);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    @(negedge clk);
    #1;
    check_eq({tag, "_done_drop"}, int'(done), 0);
    check_eq({tag, "_busy_drop"}, int'(busy), 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;

    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back(i);
    run_case("avg_n4", 1'b0, 4, 1, 100, 100, 1'b0, 1'b0);

    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back(i);
    for (int i = 0; i < 16; i++) pix_q.push_back(-(i + 1));
    run_case("max_n4_m2", 1'b1, 4, 2, 100, 100, 1'b0, 1'b0);

    pix_q = '{-1, -2, 0, 0, 32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
    run_case("avg_edges", 1'b0, 2, 3, 100, 100, 1'b0, 1'b0);

    pix_q.delete();
    for (int i = 0; i < 25; i++) pix_q.push_back(i);
    run_case("avg_n5", 1'b0, 5, 1, 100, 100, 1'b0, 1'b1);

    fill_random(16);
    run_case("stall_n4", 1'b0, 4, 1, 100, 100, 1'b1, 1'b0);

    fill_random(32 * 32 * 6);
    run_case("rand_n32", 1'($urandom), 32, 6, 70, 70, 1'b0, 1'b0);

    fill_random(7 * 7 * 3);
    run_case("rand_n7", 1'b1, 7, 3, 60, 50, 1'b0, 1'b0);

    fill_random(6 * 6 * 2);
    run_case("rand_n6_avg", 1'b0, 6, 2, 80, 40, 1'b0, 1'b0);

    // Abandon a run partway through with reset.
    @(negedge clk);
    start = 1'b1; cfg_mode = 1'b0; cfg_map_size = SZ_W'(4); cfg_num_maps = NM_W'(1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DATA_W'(i);
      @(negedge clk);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_in_ready", int'(in_ready), 0);
    check_eq("midrst_out_data", int'(out_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq("midrst_no_done", int'(done), 0);
    end

    pix_q = '{1, 9, 3, 4};
    run_case("max_n2", 1'b1, 2, 1, 100, 100, 1'b0, 1'b0);

    run_degenerate("zero_maps", 4, 0);
    run_degenerate("size_one", 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
